// File: rtl/majority_vote_sequencer_pkg.sv
// majority_vote_sequencer_pkg: shared state encoding and voter count
package majority_vote_sequencer_pkg;
  typedef enum logic {STATE_COLLECT = 1'b0, STATE_RESULT = 1'b1} state_t;
  localparam int NUM_VOTERS = 3;
endpackage

// File: rtl/majority_vote_sequencer_if.sv
// majority_vote_sequencer_if: three voter val/rdy/data channels plus result channel
//   master: voters and result consumer; slave: the sequencer
interface majority_vote_sequencer_if #(parameter int NBITS = 1);
  logic             in0_val, in0_rdy, in1_val, in1_rdy, in2_val, in2_rdy;
  logic [NBITS-1:0] in0_data, in1_data, in2_data;
  logic             out_val, out_rdy, out_quorum, out_timeout;
  logic [NBITS-1:0] out_data;
  modport master (
    output in0_val, in0_data, in1_val, in1_data, in2_val, in2_data, out_rdy,
    input  in0_rdy, in1_rdy, in2_rdy, out_val, out_data, out_quorum, out_timeout
  );
  modport slave (
    input  in0_val, in0_data, in1_val, in1_data, in2_val, in2_data, out_rdy,
    output in0_rdy, in1_rdy, in2_rdy, out_val, out_data, out_quorum, out_timeout
  );
endinterface

// File: rtl/majority_vote_sequencer_majority3.sv
// majority3_vec: bitwise 2-of-3 majority
//   a_i, b_i, c_i: NBITS inputs; y_o: per-bit majority
module majority3_vec #(parameter int NBITS = 1) (
  input  logic [NBITS-1:0] a_i,
  input  logic [NBITS-1:0] b_i,
  input  logic [NBITS-1:0] c_i,
  output logic [NBITS-1:0] y_o
);
  assign y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// File: rtl/majority_vote_sequencer.sv
// majority_vote_sequencer: collects one vote per voter, then offers the bitwise majority
//   clk, rst_n: clock and async active-low reset
//   bus (slave): in0..2 val/rdy/data voter channels, out val/rdy/data/quorum/timeout
module majority_vote_sequencer
  import majority_vote_sequencer_pkg::*;
#(
  parameter int NBITS   = 1,
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  majority_vote_sequencer_if.slave    bus
);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t                               state_q, state_d;
  logic [NUM_VOTERS-1:0]                got_q, got_d, got_n, val, rdy, acc;
  logic [NUM_VOTERS-1:0][NBITS-1:0]     vote_q, vote_n, masked, in_data;
  logic [TW-1:0]                        timer_q, timer_d;
  logic [NBITS-1:0]                     data_q, data_d, maj;
  logic                                 quorum_q, quorum_d, tout_q, tout_d, maj_got;
  logic                                 collect, done, expire;
  assign collect = state_q == STATE_COLLECT;
  assign val     = {bus.in2_val, bus.in1_val, bus.in0_val};
  assign in_data = {bus.in2_data, bus.in1_data, bus.in0_data};
  assign rdy     = ~got_q & {NUM_VOTERS{collect}};
  assign acc     = val & rdy;
  assign got_n   = got_q | acc;
  assign {bus.in2_rdy, bus.in1_rdy, bus.in0_rdy} = rdy;
  assign bus.out_val     = !collect;
  assign bus.out_data    = data_q;
  assign bus.out_quorum  = quorum_q;
  assign bus.out_timeout = tout_q;
  // Votes from voters that never answered are forced to 0 before the majority.
  always_comb
    for (int n = 0; n < NUM_VOTERS; n++) begin
      vote_n[n] = acc[n] ? in_data[n] : vote_q[n];
      masked[n] = got_n[n] ? vote_n[n] : '0;
    end
  majority3_vec #(.NBITS(NBITS)) u_data (
    .a_i(masked[0]), .b_i(masked[1]), .c_i(masked[2]), .y_o(maj)
  );
  majority3_vec #(.NBITS(1)) u_quorum (
    .a_i(got_n[0]), .b_i(got_n[1]), .c_i(got_n[2]), .y_o(maj_got)
  );
  assign done   = &got_n;
  assign expire = TIMEOUT != 0 && (|got_n) && timer_q == TW'(TIMEOUT - 1);
  // Timer starts with the first accepted vote and saturates at TIMEOUT.
  always_comb begin
    state_d  = state_q;
    got_d    = got_n;
    timer_d  = ((|got_n) || !collect) && timer_q != TW'(TIMEOUT) ? timer_q + 1'b1 : timer_q;
    data_d   = data_q;
    quorum_d = quorum_q;
    tout_d   = tout_q;
    if (collect && (done || expire)) begin
      state_d  = STATE_RESULT;
      data_d   = maj;
      quorum_d = maj_got;
      tout_d   = !done;
    end
    if (!collect && bus.out_rdy) begin
      state_d  = STATE_COLLECT;
      got_d    = '0;
      timer_d  = '0;
      data_d   = '0;
      quorum_d = 1'b0;
      tout_d   = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= STATE_COLLECT;
      got_q    <= '0;
      vote_q   <= '0;
      timer_q  <= '0;
      data_q   <= '0;
      quorum_q <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      got_q    <= got_d;
      vote_q   <= vote_n;
      timer_q  <= timer_d;
      data_q   <= data_d;
      quorum_q <= quorum_d;
      tout_q   <= tout_d;
    end
endmodule

// File: tb/tb_majority_vote_sequencer.sv
// tb_majority_vote_sequencer: directed checks of the majority vote sequencer
module tb_majority_vote_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  majority_vote_sequencer_if #(.NBITS(4)) bus ();
  majority_vote_sequencer_if #(.NBITS(1)) nt ();
  majority_vote_sequencer #(.NBITS(4), .TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  majority_vote_sequencer #(.NBITS(1), .TIMEOUT(0)) dut_nt (.clk(clk), .rst_n(rst_n), .bus(nt));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] v, input logic [3:0] d0, d1, d2);
    {bus.in2_val, bus.in1_val, bus.in0_val} = v;
    bus.in0_data = d0;
    bus.in1_data = d1;
    bus.in2_data = d2;
  endtask
  task automatic result(input string tag, input logic v, input logic [3:0] d, input logic q, t);
    check({tag, "_val"}, bus.out_val, v);
    check({tag, "_data"}, bus.out_data, d);
    check({tag, "_quorum"}, bus.out_quorum, q);
    check({tag, "_timeout"}, bus.out_timeout, t);
  endtask
  function automatic logic [2:0] rdys();
    return {bus.in2_rdy, bus.in1_rdy, bus.in0_rdy};
  endfunction
  task automatic consume(input string tag);
    bus.out_rdy = 1'b1;
    tick();
    bus.out_rdy = 1'b0;
    check({tag, "_drop"}, bus.out_val, 1'b0);
    check({tag, "_rdy"}, rdys(), 3'b111);
  endtask
  initial begin
    drive(3'b000, 4'h0, 4'h0, 4'h0);
    bus.out_rdy = 1'b0;
    {nt.in2_val, nt.in1_val, nt.in0_val} = 3'b000;
    {nt.in2_data, nt.in1_data, nt.in0_data} = 3'b000;
    nt.out_rdy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    result("reset", 1'b0, 4'h0, 1'b0, 1'b0);
    check("reset_rdy", rdys(), 3'b111);
    // separate-cycle votes 1,1,0
    drive(3'b001, 4'h1, 4'h0, 4'h0);
    tick();
    check("t1_rdy0", rdys(), 3'b110);
    drive(3'b010, 4'h0, 4'h1, 4'h0);
    tick();
    check("t1_wait", bus.out_val, 1'b0);
    drive(3'b100, 4'h0, 4'h0, 4'h0);
    tick();
    drive(3'b000, 4'h0, 4'h0, 4'h0);
    result("t1", 1'b1, 4'h1, 1'b1, 1'b0);
    check("t1_rdy", rdys(), 3'b000);
    consume("t1");
    // simultaneous votes, then a held result with voters pushing
    drive(3'b111, 4'hA, 4'h6, 4'h3);
    tick();
    drive(3'b111, 4'hF, 4'hF, 4'hF);
    result("t2", 1'b1, 4'h2, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      result("t4_hold", 1'b1, 4'h2, 1'b1, 1'b0);
      check("t4_rdy", rdys(), 3'b000);
    end
    drive(3'b000, 4'h0, 4'h0, 4'h0);
    consume("t4");
    // lone voter -> timeout
    drive(3'b100, 4'h0, 4'h0, 4'h1);
    tick();
    drive(3'b000, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t3_wait", bus.out_val, 1'b0);
    end
    tick();
    result("t3", 1'b1, 4'h0, 1'b0, 1'b1);
    consume("t3");
    // third vote on the last timer cycle
    drive(3'b001, 4'hC, 4'h0, 4'h0);
    tick();
    drive(3'b010, 4'h0, 4'hA, 4'h0);
    tick();
    drive(3'b000, 4'h0, 4'h0, 4'h0);
    tick();
    check("t5_wait", bus.out_val, 1'b0);
    drive(3'b100, 4'h0, 4'h0, 4'h6);
    tick();
    drive(3'b000, 4'h0, 4'h0, 4'h0);
    result("t5", 1'b1, 4'hE, 1'b1, 1'b0);
    consume("t5");
    // reset mid-round and during a pending result
    drive(3'b001, 4'h7, 4'h0, 4'h0);
    tick();
    drive(3'b010, 4'h0, 4'h7, 4'h0);
    tick();
    drive(3'b000, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b0;
    #1;
    check("t6_mid_val", bus.out_val, 1'b0);
    tick();
    rst_n = 1'b1;
    check("t6_mid_rdy", rdys(), 3'b111);
    drive(3'b111, 4'hF, 4'hF, 4'hF);
    tick();
    drive(3'b000, 4'h0, 4'h0, 4'h0);
    result("t6_pre", 1'b1, 4'hF, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    result("t6_res", 1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    check("t6_res_rdy", rdys(), 3'b111);
    drive(3'b110, 4'h0, 4'h5, 4'h5);
    tick();
    drive(3'b000, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 2; i++) tick();
    check("t6_clean_wait", bus.out_val, 1'b0);
    tick();
    result("t6_clean", 1'b1, 4'h5, 1'b1, 1'b1);
    consume("t6");
    // timeout disabled: a lone vote waits indefinitely
    nt.in0_val = 1'b1;
    nt.in0_data = 1'b1;
    tick();
    nt.in0_val = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check("nt_val", nt.out_val, 1'b0);
    check("nt_rdy", {nt.in2_rdy, nt.in1_rdy, nt.in0_rdy}, 3'b110);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
